// File: rtl/fetch_unit.sv
// fetch_unit -- MSP430 instruction fetch stage.
//
// Owns the program counter. Starts fetching at RST_VEC after reset and issues
// one word read per cycle on MAB_out/mem_rd. Returned MDB_in words, which
// arrive one cycle after the read strobe, go into a prefetch queue together
// with their fetch address. Decode takes the queue head over ir_valid/ir_ready.
// A taken branch flushes the queue, drops the in-flight read and redirects the PC.
//
// Configuration macro: FETCH_PREFETCH_EN
//   defined   : queue depth BUF_DEPTH, so reads overlap decode stalls and pops.
//   undefined : single-entry buffer. A read is issued only when the buffer is
//               empty and nothing is in flight.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   RST_VEC         start PC loaded during reset (bit 0 ignored)
//   MAB_out, mem_rd memory address bus (always even) and read strobe
//   MDB_in          read data, valid the cycle after mem_rd
//   branch_taken    redirect request from execute
//   branch_target   redirect PC (bit 0 ignored)
//   ir_out, ir_pc   queue head word and the address it was fetched from
//   ir_valid        queue head valid
//   ir_ready        decode accepts the head this cycle
//   pc_out          next fetch address
module fetch_unit #(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] RST_VEC,
  output logic [15:0] MAB_out,
  output logic        mem_rd,
  input  logic [15:0] MDB_in,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] ir_out,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] pc_out
);

  localparam int unsigned AW = 16;

  localparam logic [0:0] S_RESET = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  // The queue pointers wrap naturally, so the depth must be a power of two.
  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_unit: BUF_DEPTH must be a power of two and at least 2");
  end

  logic [0:0]    r_state;
  logic [0:0]    w_state_next;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] r_rd_addr;
  logic          r_inflight;
  logic          w_pop;
  logic          w_push;
  logic          w_room;
  logic          w_issue;
  logic          w_unused_bits;

  // Bit 0 of both PC sources is dropped: fetch addresses are word aligned.
  assign w_unused_bits = RST_VEC[0] ^ branch_target[0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: leave reset on the first edge with rst low.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET: w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_RESET;
    endcase
  end

  // Handshake and issue. The read strobe is combinational so that a pop in
  // this cycle frees a slot for a read in the same cycle.
  assign w_pop   = ir_valid & ir_ready;
  assign w_push  = r_inflight & (r_state == S_RUN);
  assign w_issue = ~rst & ~branch_taken & w_room;

  assign mem_rd  = w_issue;
  assign MAB_out = r_pc;
  assign pc_out  = r_pc;

  // PC and in-flight tracking. A branch clears the in-flight flag. The data of
  // that read is on MDB_in during the branch cycle and is dropped at that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= {RST_VEC[15:1], 1'b0};
      r_rd_addr  <= '0;
      r_inflight <= 1'b0;
    end else if (branch_taken) begin
      r_pc       <= {branch_target[15:1], 1'b0};
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_rd_addr <= r_pc;
        r_pc      <= r_pc + 16'd2;
      end
    end
  end

`ifdef FETCH_PREFETCH_EN

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;

  logic [AW-1:0] r_q_data [BUF_DEPTH];
  logic [AW-1:0] r_q_addr [BUF_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [OW-1:0] w_occ;

  // Occupancy projected to the end of this cycle: queued words plus the word
  // still on its way back, minus the word leaving now.
  assign w_occ  = OW'(r_count) + OW'(r_inflight) - OW'(w_pop);
  assign w_room = w_occ < OW'(BUF_DEPTH);

  assign ir_valid = (r_count != '0);
  assign ir_out   = r_q_data[r_rd_ptr];
  assign ir_pc    = r_q_addr[r_rd_ptr];

  // Circular prefetch queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_addr[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (branch_taken) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_data[r_wr_ptr] <= MDB_in;
        r_q_addr[r_wr_ptr] <= r_rd_addr;
        r_wr_ptr           <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

`else

  logic          r_full;
  logic [AW-1:0] r_q_data;
  logic [AW-1:0] r_q_addr;

  // One word at a time: fetch only into an empty buffer with nothing pending.
  assign w_room = ~r_full & ~r_inflight;

  assign ir_valid = r_full;
  assign ir_out   = r_q_data;
  assign ir_pc    = r_q_addr;

  // Single-entry buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full   <= 1'b0;
      r_q_data <= '0;
      r_q_addr <= '0;
    end else if (branch_taken) begin
      r_full <= 1'b0;
    end else if (w_push) begin
      r_q_data <= MDB_in;
      r_q_addr <= r_rd_addr;
      r_full   <= 1'b1;
    end else if (w_pop) begin
      r_full <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A queue-based model predicts the read
// strobe, the fetch address, the queue head and ir_valid on every cycle.
// Directed scenarios add literal expectations for launch, streaming,
// backpressure, branch flush, address wrap and reset/branch priority.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
  localparam bit          PF    = 1'b1;
  localparam int unsigned DEPTH = 2;
`else
  localparam bit          PF    = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] RST_VEC;
  logic [15:0] MAB_out;
  logic        mem_rd;
  logic [15:0] MDB_in;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] ir_out;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] pc_out;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .RST_VEC       (RST_VEC),
    .MAB_out       (MAB_out),
    .mem_rd        (mem_rd),
    .MDB_in        (MDB_in),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ir_out        (ir_out),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .pc_out        (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } word_t;

  word_t       m_q[$];
  int          m_infl = 0;
  logic [15:0] m_infl_addr = 16'h0;
  logic [15:0] m_pc = 16'h0;
  bit          m_known = 1'b0;
  bit          m_after_rst = 1'b0;
  bit          m_special = 1'b1;

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: address-as-data, except the launch word at 0xC000.
  function automatic logic [15:0] memf(input logic [15:0] a);
    return (m_special && a == 16'hC000) ? 16'h4031 : a;
  endfunction

  // Whether a read must be issued this cycle, from the current inputs.
  function automatic bit exp_issue();
`ifdef FETCH_PREFETCH_EN
    int pop;
    pop = (m_q.size() > 0 && ir_ready) ? 1 : 0;
`endif
    if (rst || branch_taken) return 1'b0;
`ifdef FETCH_PREFETCH_EN
    return (m_q.size() + m_infl - pop) < int'(DEPTH);
`else
    return (m_q.size() == 0) && (m_infl == 0);
`endif
  endfunction

  // Advance the model across one rising edge.
  task automatic model_step();
    bit    iss;
    bit    pop;
    word_t w;
    if (rst) begin
      m_q.delete();
      m_infl      = 0;
      m_pc        = {RST_VEC[15:1], 1'b0};
      m_known     = 1'b1;
      m_after_rst = 1'b1;
    end else if (m_known) begin
      m_after_rst = 1'b0;
      iss = exp_issue();
      pop = (m_q.size() > 0) && ir_ready;
      if (branch_taken) begin
        m_q.delete();
        m_infl = 0;
        m_pc   = {branch_target[15:1], 1'b0};
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_infl != 0) begin
          w.pc   = m_infl_addr;
          w.data = memf(m_infl_addr);
          m_q.push_back(w);
        end
        m_infl = int'(iss);
        if (iss) begin
          m_infl_addr = m_pc;
          m_pc        = m_pc + 16'd2;
        end
      end
    end
  endtask

  // Compare on the falling edge, update the model on the rising edge.
  initial begin : compare_proc
    bit e_rd;
    forever begin
      @(negedge clk);
      if (m_known) begin
        e_rd = exp_issue();
        chk1("model_mem_rd", mem_rd, e_rd);
        if (e_rd) chk16("model_mab", MAB_out, m_pc);
        chk16("model_pc_out", pc_out, m_pc);
        chk1("model_ir_valid", ir_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
          chk16("model_ir_out", ir_out, m_q[0].data);
          chk16("model_ir_pc", ir_pc, m_q[0].pc);
        end
        if (m_after_rst) begin
          chk16("model_rst_ir_out", ir_out, 16'h0000);
          chk16("model_rst_ir_pc", ir_pc, 16'h0000);
        end
      end
      @(posedge clk);
      model_step();
    end
  end

  // Memory responder: data for a read appears the cycle after its strobe.
  initial begin : mem_proc
    logic        pend;
    logic [15:0] a;
    MDB_in = 16'hDEAD;
    forever begin
      @(posedge clk);
      pend = mem_rd;
      a    = MAB_out;
      #1;
      MDB_in = pend ? memf(a) : 16'hDEAD;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // One edge with rst high; returns at the start of cycle 0.
  task automatic do_reset(input logic [15:0] vec, input bit special);
    step();
    rst          = 1'b1;
    branch_taken = 1'b0;
    RST_VEC      = vec;
    m_special    = special;
    step();
    rst = 1'b0;
  endtask

  initial begin : main
    logic [15:0] seen [3];
    int          got;
    int          k;
    bit          exp_v;

    rst           = 1'b1;
    RST_VEC       = 16'hC000;
    branch_taken  = 1'b0;
    branch_target = 16'h0000;
    ir_ready      = 1'b1;
    m_special     = 1'b1;

    // Reset launch
    step();
    sample();
    chk1 ("rst_mem_rd", mem_rd, 1'b0);
    chk16("rst_mab", MAB_out, 16'hC000);
    chk16("rst_pc_out", pc_out, 16'hC000);
    chk1 ("rst_ir_valid", ir_valid, 1'b0);
    chk16("rst_ir_out", ir_out, 16'h0000);
    chk16("rst_ir_pc", ir_pc, 16'h0000);
    step();
    rst = 1'b0;
    sample();
    chk1 ("launch_c0_mem_rd", mem_rd, 1'b1);
    chk16("launch_c0_mab", MAB_out, 16'hC000);
    step(); sample();
    chk1 ("launch_c1_valid", ir_valid, 1'b0);
    step(); sample();
    chk1 ("launch_c2_valid", ir_valid, 1'b1);
    chk16("launch_c2_ir_out", ir_out, 16'h4031);
    chk16("launch_c2_ir_pc", ir_pc, 16'hC000);

    // Streaming, address-as-data
    ir_ready = 1'b1;
    do_reset(16'hC000, 1'b0);
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      sample();
      exp_v = (c >= 2) && (PF || ((c - 2) % 3 == 0));
      chk1("stream_valid", ir_valid, exp_v);
      if (exp_v) begin
        chk16("stream_word", ir_out, 16'hC000 + 16'(2 * k));
        k++;
      end
    end

    // Backpressure: decode stalls for cycles 2..6
    ir_ready = 1'b0;
    do_reset(16'hC000, 1'b0);
    got = 0;
    for (int c = 0; c < 27; c++) begin
      if (c > 0) step();
      if (c == 7) ir_ready = 1'b1;
      sample();
      if (c == 1) chk1("bp_c1_mem_rd", mem_rd, PF);
      if (c == 4) chk1("bp_c4_mem_rd", mem_rd, 1'b0);
      if (c >= 2 && c < 7) begin
        chk1 ("bp_hold_valid", ir_valid, 1'b1);
        chk16("bp_hold_ir_out", ir_out, 16'hC000);
        chk16("bp_hold_ir_pc", ir_pc, 16'hC000);
      end
      if (c >= 7 && ir_valid && got < 3) begin
        seen[got] = ir_pc;
        got++;
      end
    end
    chk16("bp_word_count", 16'(got), 16'd3);
    for (int i = 0; i < 3; i++) chk16("bp_seq", seen[i], 16'hC000 + 16'(2 * i));

    // Branch flush with a queued word and a read in flight
    ir_ready = 1'b0;
    do_reset(16'hC000, 1'b0);
    sample();
    step(); sample();
    step();
    branch_taken  = 1'b1;
    branch_target = 16'hC101;
    sample();
    chk1("br_no_issue", mem_rd, 1'b0);
    step();
    branch_taken = 1'b0;
    ir_ready     = 1'b1;
    sample();
    chk1 ("br_c3_valid", ir_valid, 1'b0);
    chk1 ("br_c3_mem_rd", mem_rd, 1'b1);
    chk16("br_c3_mab", MAB_out, 16'hC100);
    chk16("br_c3_pc_out", pc_out, 16'hC100);
    step(); sample();
    chk1 ("br_c4_valid", ir_valid, 1'b0);
    step(); sample();
    chk1 ("br_c5_valid", ir_valid, 1'b1);
    chk16("br_c5_ir_pc", ir_pc, 16'hC100);
    chk16("br_c5_ir_out", ir_out, 16'hC100);

    // Address wrap
    ir_ready = 1'b1;
    do_reset(16'hFFFE, 1'b0);
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) step();
      sample();
      if (ir_valid && got < 2) begin
        seen[got] = ir_pc;
        got++;
      end
    end
    chk16("wrap_count", 16'(got), 16'd2);
    chk16("wrap_pc0", seen[0], 16'hFFFE);
    chk16("wrap_pc1", seen[1], 16'h0000);

    // Priority: reset beats branch, then branch with a pop delivers nothing extra
    step();
    rst           = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h1234;
    RST_VEC       = 16'hC000;
    m_special     = 1'b0;
    step();
    rst          = 1'b0;
    branch_taken = 1'b0;
    sample();
    chk16("pr_pc_out", pc_out, 16'hC000);
    chk16("pr_mab", MAB_out, 16'hC000);
    chk1 ("pr_mem_rd", mem_rd, 1'b1);
    step(); sample();
    step();
    branch_taken  = 1'b1;
    branch_target = 16'h2000;
    sample();
    chk1 ("pr_pop_valid", ir_valid, 1'b1);
    chk16("pr_pop_pc", ir_pc, 16'hC000);
    step();
    branch_taken = 1'b0;
    sample();
    chk1 ("pr_c3_valid", ir_valid, 1'b0);
    chk16("pr_c3_mab", MAB_out, 16'h2000);
    step(); sample();
    chk1 ("pr_c4_valid", ir_valid, 1'b0);
    step(); sample();
    chk1 ("pr_c5_valid", ir_valid, 1'b1);
    chk16("pr_c5_ir_pc", ir_pc, 16'h2000);
    repeat (6) begin
      step();
      sample();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
